// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Three-cycle execute sequencer that sits directly in front of an external
// 8-bit ALU. It owns the general-purpose register file and the NZCV flag
// register. Each instruction is accepted in IDLE, its operands are presented
// to the ALU during EXEC, and the result and flags are committed in WB.
// The block performs no arithmetic of its own; every value written back comes
// from the ALU.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high; aborts any instruction in flight
//   Instr_valid    : instruction fields below are valid
//   Instr_ready    : high only in IDLE; accept = Instr_valid & Instr_ready
//   Instr_op       : ALU opcode, forwarded unchanged to ALU_OP
//   Instr_rd       : destination register, also the A operand source
//   Instr_rs       : B operand source register
//   Instr_imm_sel  : B = Instr_imm instead of R[rs]
//   Instr_imm      : immediate operand
//   Instr_zero_a   : A = 0x00 instead of R[rd] (load idiom)
//   Instr_wb_en    : write result to R[rd]; when low only flags are updated
//   ALU_A / ALU_B  : registered operands, held outside EXEC
//   ALU_OP         : registered opcode, held outside EXEC
//   ALU_Result     : combinational ALU result, sampled at the end of EXEC
//   ALU_NZCV       : ALU flags, bit0 = N, bit1 = Z, bit2 = C, bit3 = V
//   Flags          : architectural flag register, same bit mapping
//   Done           : high for the single WB cycle of an instruction
//   Dbg_sel        : debug register select
//   Dbg_data       : combinational read of R[Dbg_sel]
// -----------------------------------------------------------------------------
module exec_sequencer #(
  parameter  int NUM_REGS = 4,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             Instr_valid,
  output logic             Instr_ready,
  input  logic [2:0]       Instr_op,
  input  logic [IDX_W-1:0] Instr_rd,
  input  logic [IDX_W-1:0] Instr_rs,
  input  logic             Instr_imm_sel,
  input  logic [7:0]       Instr_imm,
  input  logic             Instr_zero_a,
  input  logic             Instr_wb_en,

  output logic [7:0]       ALU_A,
  output logic [7:0]       ALU_B,
  output logic [2:0]       ALU_OP,
  input  logic [7:0]       ALU_Result,
  input  logic [3:0]       ALU_NZCV,

  output logic [3:0]       Flags,
  output logic             Done,

  input  logic [IDX_W-1:0] Dbg_sel,
  output logic [7:0]       Dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  state_e           state_q;

  // Architectural state
  logic [7:0]       regs_q [NUM_REGS];
  logic [3:0]       flags_q;

  // Operand / opcode registers presented to the ALU
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [2:0]       alu_op_q;

  // Instruction context carried from accept to write-back
  logic [IDX_W-1:0] rd_q;
  logic             wb_en_q;

  // ALU outputs captured at the end of EXEC
  logic [7:0]       res_q;
  logic [3:0]       nzcv_q;

  // Operand selection for the accept edge
  logic [7:0]       alu_a_d;
  logic [7:0]       alu_b_d;

  // NOTE: every variable written in always_comb gets a default on entry, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    alu_a_d = regs_q[Instr_rd];
    alu_b_d = regs_q[Instr_rs];
    if (Instr_zero_a)  alu_a_d = 8'h00;
    if (Instr_imm_sel) alu_b_d = Instr_imm;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples values from before the edge, independent of
  // statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      // NOTE: the register file is built from flops and is architectural
      // state, so it is cleared explicitly; a RAM macro could not be.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      flags_q  <= 4'b0000;
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_op_q <= 3'b000;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      res_q    <= 8'h00;
      nzcv_q   <= 4'b0000;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Operands read the register file as of the accept cycle; with
          // rd == rs both operands see the same value.
          if (Instr_valid) begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= Instr_op;
            rd_q     <= Instr_rd;
            wb_en_q  <= Instr_wb_en;
            state_q  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // The ALU has had the whole cycle to settle on the held operands.
          res_q   <= ALU_Result;
          nzcv_q  <= ALU_NZCV;
          state_q <= ST_WB;
        end

        ST_WB: begin
          flags_q <= nzcv_q;
          if (wb_en_q) begin
            regs_q[rd_q] <= res_q;
          end
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Instr_ready = (state_q == ST_IDLE);

  // Decoded from the state register; qualified with reset because a reset in
  // the WB cycle aborts the commit, and no completion may be signalled then.
  assign Done        = (state_q == ST_WB) && !reset;

  assign ALU_A       = alu_a_q;
  assign ALU_B       = alu_b_q;
  assign ALU_OP      = alu_op_q;
  assign Flags       = flags_q;
  assign Dbg_data    = regs_q[Dbg_sel];

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
//
// Bench for exec_sequencer. A behavioural ALU drives ALU_Result / ALU_NZCV
// from the DUT operands. A timing-based reference model (cycles elapsed since
// the last accept) predicts ready, Done, operand outputs, flags and register
// contents every cycle. A table of hand-computed instruction results, a few
// directed multi-cycle sequences and a randomized phase run on top of it.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;

  logic       clk;
  logic       reset;
  logic       Instr_valid;
  logic       Instr_ready;
  logic [2:0] Instr_op;
  logic [1:0] Instr_rd;
  logic [1:0] Instr_rs;
  logic       Instr_imm_sel;
  logic [7:0] Instr_imm;
  logic       Instr_zero_a;
  logic       Instr_wb_en;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic [2:0] ALU_OP;
  logic [7:0] ALU_Result;
  logic [3:0] ALU_NZCV;
  logic [3:0] Flags;
  logic       Done;
  logic [1:0] Dbg_sel;
  logic [7:0] Dbg_data;

  int checks = 0;
  int errors = 0;

  exec_sequencer #(.NUM_REGS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .Instr_valid   (Instr_valid),
    .Instr_ready   (Instr_ready),
    .Instr_op      (Instr_op),
    .Instr_rd      (Instr_rd),
    .Instr_rs      (Instr_rs),
    .Instr_imm_sel (Instr_imm_sel),
    .Instr_imm     (Instr_imm),
    .Instr_zero_a  (Instr_zero_a),
    .Instr_wb_en   (Instr_wb_en),
    .ALU_A         (ALU_A),
    .ALU_B         (ALU_B),
    .ALU_OP        (ALU_OP),
    .ALU_Result    (ALU_Result),
    .ALU_NZCV      (ALU_NZCV),
    .Flags         (Flags),
    .Done          (Done),
    .Dbg_sel       (Dbg_sel),
    .Dbg_data      (Dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural ALU: {nzcv, result}; nzcv bit0 = N, bit1 = Z, bit2 = C, bit3 = V
  // op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] alu_fn(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int         ia, ib, s;
    logic [7:0] r;
    logic       c, v;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin
        s = ia + ib;
        r = 8'(s);
        c = (s > 255);
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = ia - ib;
        r = 8'(s);
        c = (ia >= ib);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = 8'(ia * 2); c = a[7]; end
      default: begin r = 8'(ia / 2); c = a[0]; end
    endcase
    return {v, c, (r == 8'h00), r[7], r};
  endfunction

  always_comb begin
    {ALU_NZCV, ALU_Result} = alu_fn(ALU_OP, ALU_A, ALU_B);
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [7:0] m_regs [4];
  logic [3:0] m_flags;
  logic [7:0] m_a, m_b;
  logic [2:0] m_op;
  logic [1:0] m_rd;
  logic       m_wb;
  logic [7:0] m_res;
  logic [3:0] m_nzcv;
  int         m_since;     // cycles since the last accept edge, saturates at 3

  int         cyc;
  int         dut_acc_cyc;
  int         last_lat;
  int         acc_count;
  bit         done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags = 4'b0000;
    m_a     = 8'h00;
    m_b     = 8'h00;
    m_op    = 3'b000;
    m_since = 3;
  endtask

  // One clock cycle: check this cycle's outputs against the model, advance the
  // model across the edge, then move to 1 time unit after the edge.
  task automatic step();
    logic [11:0] r;
    #1;
    if (!reset) begin
      check("ready",  32'(Instr_ready), 32'(m_since >= 3));
      check("done",   32'(Done),        32'(m_since == 2));
      check("alu_a",  32'(ALU_A),       32'(m_a));
      check("alu_b",  32'(ALU_B),       32'(m_b));
      check("alu_op", 32'(ALU_OP),      32'(m_op));
      check("flags",  32'(Flags),       32'(m_flags));
      check("dbg",    32'(Dbg_data),    32'(m_regs[Dbg_sel]));
      if (Instr_valid && Instr_ready) begin
        dut_acc_cyc = cyc;
        acc_count++;
      end
      if (Done) begin
        last_lat  = cyc - dut_acc_cyc;
        done_seen = 1'b1;
      end
    end else begin
      check("done_in_reset", 32'(Done), 32'd0);
    end

    if (reset) begin
      model_reset();
    end else begin
      if (m_since == 2) begin
        m_flags = m_nzcv;
        if (m_wb) m_regs[m_rd] = m_res;
      end
      if (m_since >= 3 && Instr_valid) begin
        m_a  = Instr_zero_a  ? 8'h00     : m_regs[Instr_rd];
        m_b  = Instr_imm_sel ? Instr_imm : m_regs[Instr_rs];
        m_op = Instr_op;
        m_rd = Instr_rd;
        m_wb = Instr_wb_en;
        r    = alu_fn(m_op, m_a, m_b);
        m_res   = r[7:0];
        m_nzcv  = r[11:8];
        m_since = 0;
      end
      m_since = (m_since >= 3) ? 3 : m_since + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic imm_sel, input logic [7:0] imm,
                            input logic zero_a, input logic wb_en);
    Instr_op      = op;
    Instr_rd      = rd;
    Instr_rs      = rs;
    Instr_imm_sel = imm_sel;
    Instr_imm     = imm;
    Instr_zero_a  = zero_a;
    Instr_wb_en   = wb_en;
  endtask

  // Issue one instruction from IDLE and run it through WB.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic imm_sel, input logic [7:0] imm,
                       input logic zero_a, input logic wb_en);
    set_fields(op, rd, rs, imm_sel, imm, zero_a, wb_en);
    Instr_valid = 1'b1;
    step();
    Instr_valid = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       imm_sel;
    logic [7:0] imm;
    logic       zero_a;
    logic       wb_en;
    logic [1:0] chk_idx;
    logic [7:0] chk_val;
    logic [3:0] chk_flags;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int prev_acc;

    // Hand-computed expected results (flags as {V,C,Z,N})
    tbl[0] = '{3'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b1, 2'd0, 8'h7F, 4'b0000}; // load R0=7F
    tbl[1] = '{3'd0, 2'd1, 2'd0, 1'b1, 8'h01, 1'b1, 1'b1, 2'd1, 8'h01, 4'b0000}; // load R1=01
    tbl[2] = '{3'd0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h80, 4'b1001}; // ADD overflow
    tbl[3] = '{3'd2, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h80, 4'b0010}; // AND test only
    tbl[4] = '{3'd0, 2'd2, 2'd0, 1'b1, 8'h05, 1'b1, 1'b1, 2'd2, 8'h05, 4'b0000}; // load R2=05
    tbl[5] = '{3'd0, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 8'h0A, 4'b0000}; // R2+R2 alias
    tbl[6] = '{3'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h00, 4'b0110}; // R1-R1
    tbl[7] = '{3'd0, 2'd3, 2'd0, 1'b1, 8'hFF, 1'b1, 1'b1, 2'd3, 8'hFF, 4'b0001}; // load R3=FF
    tbl[8] = '{3'd0, 2'd3, 2'd0, 1'b1, 8'h01, 1'b0, 1'b1, 2'd3, 8'h00, 4'b0110}; // FF+1 carry

    cyc = 0; dut_acc_cyc = 0; last_lat = 0; acc_count = 0; done_seen = 1'b0;
    Instr_valid = 1'b0;
    Dbg_sel     = 2'd0;
    set_fields(3'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();

    // Reset and reset-state checks
    reset = 1'b1;
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    #1;
    check("rst_ready",  32'(Instr_ready), 32'd1);
    check("rst_done",   32'(Done),        32'd0);
    check("rst_flags",  32'(Flags),       32'd0);
    check("rst_alu_a",  32'(ALU_A),       32'd0);
    check("rst_alu_b",  32'(ALU_B),       32'd0);
    check("rst_alu_op", 32'(ALU_OP),      32'd0);
    for (int i = 0; i < 4; i++) begin
      Dbg_sel = 2'(i);
      #1;
      check("rst_reg", 32'(Dbg_data), 32'd0);
    end
    step();

    // Table-driven instructions, issued back to back
    prev_acc = 0;
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm_sel, tbl[i].imm,
            tbl[i].zero_a, tbl[i].wb_en);
      Dbg_sel = tbl[i].chk_idx;
      #1;
      check("tbl_reg",      32'(Dbg_data), 32'(tbl[i].chk_val));
      check("tbl_flags",    32'(Flags),    32'(tbl[i].chk_flags));
      check("tbl_done_lat", 32'(last_lat), 32'd2);
      if (i > 0) check("tbl_acc_spacing", 32'(dut_acc_cyc - prev_acc), 32'd3);
      prev_acc = dut_acc_cyc;
    end

    // Debug port: old value during WB, new value the cycle after
    Dbg_sel = 2'd0;
    set_fields(3'd0, 2'd0, 2'd0, 1'b1, 8'h33, 1'b1, 1'b1);
    Instr_valid = 1'b1;
    step();
    Instr_valid = 1'b0;
    step();
    #1;
    check("dbg_wb_done", 32'(Done),     32'd1);
    check("dbg_wb_old",  32'(Dbg_data), 32'h80);
    step();
    #1;
    check("dbg_new", 32'(Dbg_data), 32'h33);

    // Reset held for two cycles while an ADD is in EXEC
    set_fields(3'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    Instr_valid = 1'b1;
    step();
    Instr_valid = 1'b0;
    done_seen   = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_no_done", 32'(done_seen),   32'd0);
    check("abort_ready",   32'(Instr_ready), 32'd1);
    check("abort_flags",   32'(Flags),       32'd0);
    for (int i = 0; i < 4; i++) begin
      Dbg_sel = 2'(i);
      #1;
      check("abort_reg", 32'(Dbg_data), 32'd0);
    end

    // Seed registers, then hold valid high with fields changing every cycle
    issue(3'd0, 2'd1, 2'd0, 1'b1, 8'h11, 1'b1, 1'b1);
    issue(3'd0, 2'd2, 2'd0, 1'b1, 8'h22, 1'b1, 1'b1);
    acc_count   = 0;
    Instr_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_fields(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                 8'($urandom), 1'($urandom), 1'($urandom));
      Dbg_sel = 2'($urandom);
      step();
    end
    Instr_valid = 1'b0;
    check("held_valid_accepts", 32'(acc_count), 32'd5);
    step(); step(); step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      Instr_valid = 1'($urandom_range(0, 1));
      set_fields(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                 8'($urandom), 1'($urandom), 1'($urandom));
      Dbg_sel = 2'($urandom);
      reset   = ($urandom_range(0, 60) == 0);
      step();
    end
    reset       = 1'b0;
    Instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Dbg_sel = 2'(i);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
